// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the shared instruction/data memory.
// The slave modport is the arbiter's view; master is the CPU/memory environment.
interface imem_port_arbiter_if #(
   parameter int unsigned IDX_W = 11
);
   logic             if_req;
   logic [31:0]      if_addr;
   logic             if_gnt;
   logic             if_rvalid;
   logic [31:0]      if_rdata;
   logic             if_flush;

   logic             dm_req;
   logic             dm_we;
   logic [31:0]      dm_addr;
   logic [31:0]      dm_wdata;
   logic             dm_gnt;
   logic             dm_rvalid;
   logic [31:0]      dm_rdata;
   logic             dm_err;

   logic             mem_en;
   logic             mem_we;
   logic [IDX_W-1:0] mem_addr;
   logic [31:0]      mem_wdata;
   logic [31:0]      mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_gnt, if_rvalid, if_rdata,
      output dm_gnt, dm_rvalid, dm_rdata, dm_err,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_flush,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_gnt, if_rvalid, if_rdata,
      input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and data (DM) ports: data priority with a
// bounded-starvation override for fetch, and an in-order tag pipeline that routes read responses.
module imem_port_arbiter #(
   parameter int unsigned IDX_W      = 11,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                clk,
   input logic                rst_n,
   imem_port_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic valid;
      logic owner_dm;
      logic err;
   } tag_t;

   logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
   tag_t [MEM_LAT-1:0]       pipe_q, pipe_d;
   tag_t                     new_tag;
   tag_t                     last_tag;
   logic                     starved;
   logic                     if_gnt, dm_gnt;
   logic                     dm_legal;
   logic                     unused_if_bits;

   assign unused_if_bits = ^{bus.if_addr[31:IDX_W+2], bus.if_addr[1:0]};

   // Arbitration: DM wins unless fetch has been passed over STARVE_MAX times in a row.
   always_comb begin
      starved  = (starve_cnt_q == CNT_W'(STARVE_MAX));
      if_gnt   = bus.if_req && (!bus.dm_req || starved);
      dm_gnt   = bus.dm_req && !if_gnt;
      dm_legal = (bus.dm_addr[1:0] == 2'b00) && (bus.dm_addr[31:IDX_W+2] == '0);
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!bus.if_req || if_gnt) begin
         starve_cnt_d = '0;
      end else if (dm_gnt && !starved) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.dm_gnt    = dm_gnt;
   assign bus.mem_en    = if_gnt || (dm_gnt && dm_legal);
   assign bus.mem_we    = dm_gnt && dm_legal && bus.dm_we;
   assign bus.mem_addr  = if_gnt ? bus.if_addr[IDX_W+1:2] : bus.dm_addr[IDX_W+1:2];
   assign bus.mem_wdata = bus.dm_wdata;

   // Legal DM writes produce no response; illegal accesses always answer with an error.
   always_comb begin
      new_tag.valid    = if_gnt || (dm_gnt && (!bus.dm_we || !dm_legal));
      new_tag.owner_dm = dm_gnt;
      new_tag.err      = dm_gnt && !dm_legal;
   end

   // The tag entering this cycle survives a flush; older fetch tags do not.
   always_comb begin
      pipe_d    = '0;
      pipe_d[0] = new_tag;
      for (int k = 1; k < int'(MEM_LAT); k++) begin
         pipe_d[k] = pipe_q[k-1];
         if (bus.if_flush && !pipe_q[k-1].owner_dm) begin
            pipe_d[k].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
         pipe_q       <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         pipe_q       <= pipe_d;
      end
   end

   assign last_tag      = pipe_q[MEM_LAT-1];
   assign bus.if_rvalid = last_tag.valid && !last_tag.owner_dm && !bus.if_flush;
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
   assign bus.dm_rvalid = last_tag.valid && last_tag.owner_dm;
   assign bus.dm_err    = bus.dm_rvalid && last_tag.err;
   assign bus.dm_rdata  = (bus.dm_rvalid && !last_tag.err) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_imem_port_arbiter;
   localparam int unsigned LAT = 2;
   localparam int unsigned N   = 28;
   localparam logic        H   = 1'b1;
   localparam logic        L   = 1'b0;
   localparam logic [31:0] Z   = 32'h0;

   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        ifl;
      logic        dmr;
      logic        dwe;
      logic [31:0] dma;
      logic [31:0] dwd;
      logic        ig;
      logic        dg;
      logic        en;
      logic        we;
      logic [10:0] ma;
      logic        irv;
      logic [31:0] ird;
      logic        drv;
      logic [31:0] drd;
      logic        der;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   imem_port_arbiter_if #(.IDX_W(11)) bus ();

   imem_port_arbiter #(
      .IDX_W      (11),
      .MEM_LAT    (LAT),
      .STARVE_MAX (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: reads return after LAT cycles; junk marks cycles with no read issued.
   logic [31:0] mem [2048];
   logic [31:0] rd_pipe [LAT];

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr] : 32'hBAD0_BAD0;
      for (int k = 1; k < int'(LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
   end

   assign bus.mem_rdata = rd_pipe[LAT-1];

   function automatic vec_t mk(
      input logic ifr, input logic [31:0] ifa, input logic ifl,
      input logic dmr, input logic dwe, input logic [31:0] dma, input logic [31:0] dwd,
      input logic ig, input logic dg, input logic en, input logic we, input logic [10:0] ma,
      input logic irv, input logic [31:0] ird,
      input logic drv, input logic [31:0] drd, input logic der);
      vec_t v;
      v.ifr = ifr; v.ifa = ifa; v.ifl = ifl;
      v.dmr = dmr; v.dwe = dwe; v.dma = dma; v.dwd = dwd;
      v.ig = ig; v.dg = dg; v.en = en; v.we = we; v.ma = ma;
      v.irv = irv; v.ird = ird; v.drv = drv; v.drd = drd; v.der = der;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.if_req   = 1'b0;
      bus.if_addr  = 32'h0;
      bus.if_flush = 1'b0;
      bus.dm_req   = 1'b0;
      bus.dm_we    = 1'b0;
      bus.dm_addr  = 32'h0;
      bus.dm_wdata = 32'h0;
   endtask

   task automatic chk_quiet(input string name, input int idx);
      chk({name, "_resp"}, idx,
          {30'h0, bus.if_rvalid, bus.dm_rvalid, bus.dm_err, bus.if_rdata == Z, bus.dm_rdata == Z},
          {30'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
   endtask

   vec_t       vecs [N];
   logic [11:0] starve_exp;
   logic [4:0]  post_rst_exp;

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
      for (int k = 0; k < int'(LAT); k++) rd_pipe[k] = 32'hBAD0_BAD0;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2009_0003;
      mem[2] = 32'h0109_5020;

      //              ifr ifa          ifl dmr dwe dma          dwd           ig dg en we ma
      vecs[0]  = mk(H, 32'h0,       L, L, L, Z,           Z,            H, L, H, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[1]  = mk(H, 32'h4,       L, L, L, Z,           Z,            H, L, H, L, 11'h001,
                    L, Z, L, Z, L);
      vecs[2]  = mk(H, 32'h8,       L, L, L, Z,           Z,            H, L, H, L, 11'h002,
                    H, 32'h2008_0005, L, Z, L);
      vecs[3]  = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    H, 32'h2009_0003, L, Z, L);
      vecs[4]  = mk(L, Z,           L, H, H, 32'h100,     32'hDEAD_BEEF, L, H, H, H, 11'h040,
                    H, 32'h0109_5020, L, Z, L);
      vecs[5]  = mk(L, Z,           L, H, L, 32'h100,     Z,            L, H, H, L, 11'h040,
                    L, Z, L, Z, L);
      vecs[6]  = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[7]  = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, H, 32'hDEAD_BEEF, L);
      vecs[8]  = mk(L, Z,           L, H, L, 32'h102,     Z,            L, H, L, L, 11'h040,
                    L, Z, L, Z, L);
      vecs[9]  = mk(L, Z,           L, H, L, 32'h2000,    Z,            L, H, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[10] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, H, Z, H);
      vecs[11] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, H, Z, H);
      vecs[12] = mk(L, Z,           L, H, L, 32'h4,       Z,            L, H, H, L, 11'h001,
                    L, Z, L, Z, L);
      vecs[13] = mk(H, 32'h0,       L, L, L, Z,           Z,            H, L, H, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[14] = mk(H, 32'h8,       H, L, L, Z,           Z,            H, L, H, L, 11'h002,
                    L, Z, H, 32'h2009_0003, L);
      vecs[15] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[16] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    H, 32'h0109_5020, L, Z, L);
      vecs[17] = mk(H, 32'h4,       L, L, L, Z,           Z,            H, L, H, L, 11'h001,
                    L, Z, L, Z, L);
      vecs[18] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[19] = mk(L, Z,           H, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[20] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[21] = mk(H, 32'hFFFF_E007, L, L, L, Z,         Z,            H, L, H, L, 11'h001,
                    L, Z, L, Z, L);
      vecs[22] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[23] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    H, 32'h2009_0003, L, Z, L);
      vecs[24] = mk(H, 32'h0,       L, H, L, 32'h8,       Z,            L, H, H, L, 11'h002,
                    L, Z, L, Z, L);
      vecs[25] = mk(H, 32'h0,       L, L, L, Z,           Z,            H, L, H, L, 11'h000,
                    L, Z, L, Z, L);
      vecs[26] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    L, Z, H, 32'h0109_5020, L);
      vecs[27] = mk(L, Z,           L, L, L, Z,           Z,            L, L, L, L, 11'h000,
                    H, 32'h2008_0005, L, Z, L);

      drive_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_quiet("reset", 0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < int'(N); i++) begin
         @(posedge clk);
         #1;
         bus.if_req   = vecs[i].ifr;
         bus.if_addr  = vecs[i].ifa;
         bus.if_flush = vecs[i].ifl;
         bus.dm_req   = vecs[i].dmr;
         bus.dm_we    = vecs[i].dwe;
         bus.dm_addr  = vecs[i].dma;
         bus.dm_wdata = vecs[i].dwd;
         @(negedge clk);
         chk("grant", i, {62'h0, bus.if_gnt, bus.dm_gnt}, {62'h0, vecs[i].ig, vecs[i].dg});
         if (vecs[i].ig || vecs[i].dg)
            chk("mem_drive", i, {51'h0, bus.mem_en, bus.mem_we, bus.mem_addr},
                {51'h0, vecs[i].en, vecs[i].we, vecs[i].ma});
         else
            chk("mem_en", i, {63'h0, bus.mem_en}, 64'h0);
         chk("if_resp", i, {31'h0, bus.if_rvalid, bus.if_rdata},
             {31'h0, vecs[i].irv, vecs[i].ird});
         chk("dm_resp", i, {30'h0, bus.dm_rvalid, bus.dm_err, bus.dm_rdata},
             {30'h0, vecs[i].drv, vecs[i].der, vecs[i].drd});
      end

      // Both ports held busy: fetch forced in after four consecutive data grants.
      starve_exp = 12'h210;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         bus.if_req  = 1'b1;
         bus.if_addr = 32'h0;
         bus.dm_req  = 1'b1;
         bus.dm_we   = 1'b0;
         bus.dm_addr = 32'h4;
         @(negedge clk);
         chk("starve_grant", i, {62'h0, bus.if_gnt, bus.dm_gnt},
             {62'h0, starve_exp[i], ~starve_exp[i]});
      end
      @(posedge clk);
      #1 drive_idle();
      repeat (LAT + 1) @(posedge clk);

      // Reset with responses in flight and the starvation counter at 3.
      #1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h0;
      @(negedge clk);
      chk("pre_rst_if_gnt", 0, {63'h0, bus.if_gnt}, 64'h1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         bus.dm_req  = 1'b1;
         bus.dm_addr = 32'h4;
         @(negedge clk);
         chk("pre_rst_dm_gnt", i, {62'h0, bus.if_gnt, bus.dm_gnt}, 64'h1);
      end
      @(posedge clk);
      #1;
      drive_idle();
      rst_n = 1'b0;
      #1;
      chk_quiet("rst_assert", 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < int'(LAT) + 1; i++) begin
         @(negedge clk);
         chk_quiet("post_rst", i);
         @(posedge clk);
      end
      // A retained count would force fetch after the first data grant.
      post_rst_exp = 5'b10000;
      for (int i = 0; i < 5; i++) begin
         #1;
         bus.if_req  = 1'b1;
         bus.dm_req  = 1'b1;
         bus.dm_addr = 32'h4;
         @(negedge clk);
         chk("post_rst_grant", i, {62'h0, bus.if_gnt, bus.dm_gnt},
             {62'h0, post_rst_exp[i], ~post_rst_exp[i]});
         @(posedge clk);
      end
      #1 drive_idle();
      repeat (LAT + 1) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
